// File: rtl/axi_mem_responder.sv
// AXI3-style single-burst slave backed by on-chip RAM (256-bit beats, byte strobes).
// Optional AXI_RESP_BACKPRESSURE_EN macro adds LFSR-driven pseudo-random stalls.
module axi_mem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter int          ADDR_LSB   = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic         axi_clk,
    input  logic         rstn,
    input  logic [7:0]   aid,
    input  logic [31:0]  aaddr,
    input  logic [7:0]   alen,
    input  logic [2:0]   asize,
    input  logic [1:0]   aburst,
    input  logic [1:0]   alock,
    input  logic         atype,
    input  logic         avalid,
    output logic         aready,
    input  logic [7:0]   wid,
    input  logic [255:0] wdata,
    input  logic [31:0]  wstrb,
    input  logic         wlast,
    input  logic         wvalid,
    output logic         wready,
    output logic [7:0]   bid,
    output logic [1:0]   bresp,
    output logic         bvalid,
    input  logic         bready,
    output logic [7:0]   rid,
    output logic [255:0] rdata,
    output logic [1:0]   rresp,
    output logic         rlast,
    output logic         rvalid,
    input  logic         rready,
    output logic [7:0]   err_cnt,
    output logic [1:0]   dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2,
        R_DATA = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [255:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx, idx_adv, raddr;
    logic [7:0]            remaining;
    logic                  fixed_q, err_q, err_nxt;
    logic                  a_hs, w_hs, b_hs, r_hs, last_beat, a_err;
    logic                  stall_next;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; a raised valid is held, with its payload stable, until that edge.
    assign a_hs      = (state == IDLE)   && avalid && aready;
    assign w_hs      = (state == W_DATA) && wvalid && wready;
    assign b_hs      = (state == W_RESP) && bvalid && bready;
    assign r_hs      = (state == R_DATA) && rvalid && rready;
    assign last_beat = (remaining == 8'd0);
    assign a_err     = (asize != 3'd5) || aburst[1];
    assign idx_adv   = fixed_q ? idx : idx + IDX_ONE;
    // Prefetch the next beat on a read handshake so rready-high bursts have no bubbles.
    assign raddr     = r_hs ? idx_adv : idx;
    assign dbg_state = state;

`ifdef AXI_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr, lfsr_nxt;
    logic        unused;

    assign lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign stall_next = (lfsr_nxt[1:0] == 2'b00);
    assign unused     = ^{alock, wid, aaddr[31:ADDR_LSB+DEPTH_LOG2], aaddr[ADDR_LSB-1:0]};

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_nxt;
    end
`else
    logic unused;

    assign stall_next = 1'b0;
    assign unused     = ^{alock, wid, aaddr[31:ADDR_LSB+DEPTH_LOG2], aaddr[ADDR_LSB-1:0], LFSR_SEED};
`endif

    always_comb begin
        err_nxt = err_q;
        if (a_hs)
            err_nxt = a_err;
        else if (w_hs && (wlast != last_beat))
            err_nxt = 1'b1;
    end

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_hs) state_nxt = atype ? W_DATA : R_DATA;
            W_DATA:  if (w_hs && last_beat) state_nxt = W_RESP;
            W_RESP:  if (b_hs) state_nxt = IDLE;
            R_DATA:  if (r_hs && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            idx       <= '0;
            remaining <= 8'd0;
            fixed_q   <= 1'b0;
            err_q     <= 1'b0;
            aready    <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
            bid       <= 8'd0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rresp     <= 2'b00;
            rid       <= 8'd0;
            err_cnt   <= 8'd0;
        end else begin
            err_q  <= err_nxt;
            aready <= (state_nxt == IDLE)   && !stall_next;
            wready <= (state_nxt == W_DATA) && !stall_next;

            if (a_hs) begin
                idx       <= aaddr[ADDR_LSB +: DEPTH_LOG2];
                remaining <= alen;
                fixed_q   <= (aburst == 2'b00);
                bid       <= aid;
                rid       <= aid;
            end else if (w_hs || r_hs) begin
                idx       <= idx_adv;
                remaining <= remaining - 8'd1;
            end

            if (w_hs && last_beat) begin
                bvalid <= !stall_next;
                bresp  <= err_nxt ? 2'b10 : 2'b00;
            end else if ((state == W_RESP) && !bvalid) begin
                bvalid <= 1'b1;
            end else if (b_hs) begin
                bvalid <= 1'b0;
            end

            // First rvalid waits one cycle in R_DATA so the RAM output holds beat 0.
            if ((state == R_DATA) && !rvalid && !stall_next) begin
                rvalid <= 1'b1;
                rlast  <= last_beat;
                rresp  <= err_q ? 2'b10 : 2'b00;
            end else if (r_hs) begin
                if (last_beat) begin
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                end else begin
                    rlast  <= (remaining == 8'd1);
                end
            end

            if ((b_hs || (r_hs && last_beat)) && err_q && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge axi_clk) begin
        for (int i = 0; i < 32; i++) begin
            if (w_hs && wstrb[i])
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[raddr];
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI3-style slave that terminates the shared-address-channel bus driven by the team's AXI traffic initiators (memory checkers, DMA testers) and backs it with on-chip RAM. Accepts one write or read burst at a time, stores write beats with byte strobes, returns write responses and read bursts. Used as a DDR stand-in for simulation and on-board loopback of initiator logic.

## Interface
- DEPTH_LOG2, 8, RAM depth in 256-bit beats (2^DEPTH_LOG2)
- ADDR_LSB, 5, byte-address bits below beat index (32 bytes/beat)
- LFSR_SEED, 16'hACE1, stall LFSR seed (used only with AXI_RESP_BACKPRESSURE_EN)
- axi_clk  in  1  sole clock, all logic rising-edge
- rstn  in  1  asynchronous active-low reset
- aid  in  8  transaction ID; aaddr  in  32  byte address; alen  in  8  beats-1; asize  in  3; aburst  in  2; alock  in  2 (ignored)
- atype  in  1  1=write, 0=read; avalid  in  1; aready  out  1
- wid  in  8 (ignored); wdata  in  256; wstrb  in  32; wlast  in  1; wvalid  in  1; wready  out  1
- bid  out  8; bresp  out  2; bvalid  out  1; bready  in  1
- rid  out  8; rdata  out  256; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
- err_cnt  out  8  saturating count of SLVERR responses issued

## Operation
- States: IDLE, W_DATA, W_RESP, R_DATA.
- IDLE: aready=1. On avalid&aready: latch aid, index=aaddr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB], remaining=alen, err flag; go W_DATA if atype else R_DATA. aready drops next cycle.
- err flag set when asize!=5 or aburst==2'b11 (reserved) or aburst==2'b10 (WRAP, unsupported); burst still executed as INCR.
- Index update per beat: aburst 2'b00 FIXED holds index; all others increment modulo 2^DEPTH_LOG2 (wraps silently, no error).
- W_DATA: wready=1. Each wvalid&wready writes lanes where wstrb[i]=1 at index. Beat count alen+1; wlast must equal (remaining==0); mismatch sets err flag. Exit to W_RESP after beat alen+1 regardless of wlast.
- W_RESP: bvalid=1, bid=latched ID, bresp=err?2'b10:2'b00; hold until bready; then IDLE.
- R_DATA: rvalid, rdata=RAM[index], rid=latched ID, rlast=(remaining==0), rresp=err?2'b10:2'b00 on every beat. Advance on rvalid&rready; after last beat go IDLE.
- err_cnt increments once per burst with err flag, at bvalid&bready or final read beat handshake; saturates at 255.
- avalid while not IDLE is ignored (aready=0).
- RAM contents are not reset.

## Timing
- Reset: aready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, err_cnt=0, state IDLE; aready=1 first cycle after rstn release.
- All outputs registered except rdata (direct synchronous-RAM output).
- Write: handshake at cycle T -> wready=1 at T+1; with wvalid held, beat n accepted at T+1+n; bvalid at cycle after final beat.
- Read: handshake at T -> rvalid at T+2 (one fetch cycle). With rready high, one beat per cycle, no bubbles; RAM read address = index+1 on a beat handshake, else index, so rdata stable while rvalid&!rready.
- Read-after-write same index: write completes before W_RESP, so the next burst reads new data.
- Reset mid-burst: all handshake outputs deassert asynchronously; partially written beats remain in RAM.

## Configuration
- AXI_RESP_BACKPRESSURE_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded LFSR_SEED at reset, advances every cycle; when lfsr[1:0]==2'b00 aready, wready and rvalid assertion is withheld that cycle (rvalid never drops once asserted until handshake). bvalid delayed one cycle on stall.
- Undefined: no LFSR, no stalls; timing exactly as above.

## Test plan
- Write aaddr=0x0, alen=23, asize=5, INCR, wstrb all-ones, data=beat number; read back same -> 24 beats match, rlast on beat 24, bresp=rresp=0, err_cnt=0.
- Write one beat 0xFF..FF at 0x40 with wstrb=32'h0000_000F, then read -> bytes 0-3 0xFF, bytes 4-31 previous value.
- Write with asize=3 alen=0 -> bresp=2'b10, err_cnt=1; write with wlast low on final beat -> bresp=2'b10, err_cnt=2.
- Write INCR starting at index 255, alen=1 -> second beat lands at index 0; FIXED burst alen=3 -> only final beat's data remains at index.
- Read alen=7 with rready toggling every other cycle -> rdata stable while stalled, 8 beats in order, correct rid=0x5A.
- Assert rstn low mid-write burst (beat 5 of 24) -> wready, bvalid 0 immediately; after release aready=1 next cycle, beats 0-4 readable; with AXI_RESP_BACKPRESSURE_EN, first test still passes with stalls observed.
